// File: rtl/seq_div.sv
// seq_div: 4-step restoring divider on sign-magnitude operands (5-bit dividend / 3-bit divisor).
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   i_start          begin a division (sampled only in IDLE)
//   i_dividend[4:0]  sign-magnitude, [4]=sign, [3:0]=magnitude
//   i_divisor[2:0]   sign-magnitude, [2]=sign, [1:0]=magnitude
//   o_quotient[4:0]  sign-magnitude result, held until the next completion
//   o_remainder[2:0] sign-magnitude remainder (only with DIV_REM_EN)
//   o_busy           high while iterating
//   o_done           one-cycle pulse when results become valid
//   o_zero_flag      quotient magnitude is zero
//   o_negative_flag  quotient sign bit
//   o_div_by_zero    last accepted divisor magnitude was zero
// Build option: define DIV_REM_EN to expose the remainder port and register.
module seq_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [4:0] i_dividend,
    input  logic [2:0] i_divisor,
    output logic [4:0] o_quotient,
`ifdef DIV_REM_EN
    output logic [2:0] o_remainder,
`endif
    output logic       o_busy,
    output logic       o_done,
    output logic       o_zero_flag,
    output logic       o_negative_flag,
    output logic       o_div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     r_state, w_next;
    logic [3:0] r_q;
    logic [1:0] r_rem, r_dvs, r_cnt;
    logic       r_qs, r_dbz_pend, r_dbz;
    logic [4:0] r_quot;
    logic       w_accept, w_last, w_qbit;
    logic [2:0] w_shift;
    logic [3:0] w_diff, w_qmag;
    logic [1:0] w_rem_n;
`ifdef DIV_REM_EN
    logic       r_rs;
    logic [2:0] r_remo;
`endif
    assign w_accept = (r_state == IDLE) && i_start && !r_dbz_pend;
    assign w_last   = (r_state == RUN) && (r_cnt == 2'd3);
    // r_q holds unconsumed dividend bits at the top and new quotient bits at the bottom
    assign w_shift  = {r_rem, r_q[3]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_qbit   = ~w_diff[3];
    assign w_rem_n  = w_qbit ? w_diff[1:0] : w_shift[1:0];
    assign w_qmag   = {r_q[2:0], w_qbit};
    // A zero divisor waits one cycle in IDLE (r_dbz_pend) so DONE lands one edge after
    // the start without ever passing through RUN.
    always_comb begin
        w_next = (r_state == IDLE) ? (r_dbz_pend ? DONE : (w_accept && |i_divisor[1:0]) ? RUN : IDLE)
               : (r_state == RUN)  ? (w_last ? DONE : RUN)
               : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_cnt      <= '0;
            r_qs       <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_dbz      <= 1'b0;
            r_quot     <= '0;
`ifdef DIV_REM_EN
            r_rs       <= 1'b0;
            r_remo     <= '0;
`endif
        end else begin
            r_dbz_pend <= w_accept && (i_divisor[1:0] == 2'b00);
            if (w_accept) begin
                r_q   <= i_dividend[3:0];
                r_rem <= '0;
                r_cnt <= '0;
                r_dvs <= i_divisor[1:0];
                r_qs  <= i_dividend[4] ^ i_divisor[2];
`ifdef DIV_REM_EN
                r_rs  <= i_dividend[4];
`endif
            end else if (r_state == RUN) begin
                r_q   <= w_qmag;
                r_rem <= w_rem_n;
                r_cnt <= r_cnt + 2'd1;
            end
            if (r_dbz_pend) begin
                r_quot <= '0;
                r_dbz  <= 1'b1;
`ifdef DIV_REM_EN
                r_remo <= '0;
`endif
            end else if (w_last) begin
                r_quot <= {r_qs && |w_qmag, w_qmag};
                r_dbz  <= 1'b0;
`ifdef DIV_REM_EN
                r_remo <= {r_rs && |w_rem_n, w_rem_n};
`endif
            end
        end
    end
    assign o_quotient      = r_quot;
`ifdef DIV_REM_EN
    assign o_remainder     = r_remo;
`endif
    assign o_busy          = (r_state == RUN);
    assign o_done          = (r_state == DONE);
    assign o_zero_flag     = (r_quot[3:0] == 4'd0);
    assign o_negative_flag = r_quot[4];
    assign o_div_by_zero   = r_dbz;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized and directed checks of seq_div against an arithmetic reference model.
// Ports: none (drives clk, rst, i_start, i_dividend, i_divisor; observes all outputs).
module tb_seq_div;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [4:0] dividend = '0, quotient;
    logic [2:0] divisor = '0;
`ifdef DIV_REM_EN
    logic [2:0] remainder;
`endif
    logic       busy, done, zero_flag, negative_flag, div_by_zero;
    int         n_chk = 0, n_fail = 0;

    seq_div dut (
        .clk(clk), .rst(rst), .i_start(start), .i_dividend(dividend), .i_divisor(divisor),
        .o_quotient(quotient),
`ifdef DIV_REM_EN
        .o_remainder(remainder),
`endif
        .o_busy(busy), .o_done(done), .o_zero_flag(zero_flag),
        .o_negative_flag(negative_flag), .o_div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, quotient[4:0], remainder[2:0]} from plain integer division.
    function automatic logic [8:0] model(input logic [4:0] a, input logic [2:0] b);
        int  qm, rm;
        logic qs, rs;
        if (b[1:0] == 2'b00) return {1'b1, 5'b0, 3'b0};
        qm = int'(a[3:0]) / int'(b[1:0]);
        rm = int'(a[3:0]) % int'(b[1:0]);
        qs = (a[4] ^ b[2]) && (qm != 0);
        rs = a[4] && (rm != 0);
        return {1'b0, qs, 4'(qm), rs, 2'(rm)};
    endfunction

    // Starts a division and checks latency, busy duration, results and the done pulse.
    // With interfere set, a second start with other operands is driven mid-run.
    task automatic run_div(input logic [4:0] a, input logic [2:0] b, input bit interfere);
        logic [8:0] exp;
        int lat, nbusy;
        exp = model(a, b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 99; nbusy = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin lat = k; break; end
            if (busy) nbusy++;
            if (interfere && k == 1) begin
                start = 1'b1; dividend = 5'b0_1111; divisor = 3'b0_01;
            end
            if (interfere && k == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        check("latency", lat, exp[8] ? 1 : 4);
        check("busy_cycles", nbusy, exp[8] ? 0 : 4);
        check("quotient", quotient, exp[7:3]);
`ifdef DIV_REM_EN
        check("remainder", remainder, exp[2:0]);
`endif
        check("zero_flag", zero_flag, exp[6:3] == 4'd0);
        check("negative_flag", negative_flag, exp[7]);
        check("div_by_zero", div_by_zero, exp[8]);
        check("busy_in_done", busy, 0);
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);
        check("quotient_hold", quotient, exp[7:3]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", quotient, 0);
`ifdef DIV_REM_EN
        check("rst_remainder", remainder, 0);
`endif
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_zero_flag", zero_flag, 1);
        check("rst_negative_flag", negative_flag, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        rst = 1'b0;

        run_div(5'b0_1101, 3'b0_11, 0);
        run_div(5'b1_1001, 3'b0_10, 0);
        run_div(5'b1_0001, 3'b0_11, 0);
        run_div(5'b0_0111, 3'b1_00, 0);
        run_div(5'b1_1111, 3'b1_01, 0);
        run_div(5'b0_1110, 3'b0_11, 1);
        for (int i = 0; i < 40; i++)
            run_div(5'($urandom), 3'($urandom), 0);

        // Reset two edges into a run: aborted, cleared, no done pulse.
        run_div(5'b1_1011, 3'b0_10, 0);
        @(negedge clk);
        start = 1'b1; dividend = 5'b0_1101; divisor = 3'b0_11;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_zero_flag", zero_flag, 1);
        check("abort_negative_flag", negative_flag, 0);
        begin
            int ndone = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                if (done || busy) ndone++;
            end
            check("abort_no_activity", ndone, 0);
        end

        // Reset and start at the same edge: reset wins.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; divisor = 3'b0_01;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_priority_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 dividend  input  5  sign-magnitude; [4]=sign, [3:0]=magnitude (same format as multiplier result).
REQ-006 divisor  input  3  sign-magnitude; [2]=sign, [1:0]=magnitude (same format as multiplier operands).
REQ-007 quotient  output  5  sign-magnitude; [4]=sign, [3:0]=magnitude.
REQ-008 remainder  output  3  sign-magnitude; [2]=sign, [1:0]=magnitude; present only with DIV_REM_EN.
REQ-009 busy  output  1  high while iterating.
REQ-010 done  output  1  one-cycle pulse when results become valid.
REQ-011 zeroFlag  output  1  high when quotient magnitude is 0.
REQ-012 negativeFlag  output  1  high when quotient sign bit is 1.
REQ-013 divByZero  output  1  high when last accepted divisor magnitude was 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 In IDLE, start=1 at edge N SHALL latch both operands, clear the partial remainder and iteration count, and enter RUN (or DONE if divisor[1:0]==0).
REQ-016 RUN SHALL perform one restoring-division step per edge, MSB first: shift, trial-subtract divisor magnitude, keep difference and set quotient bit to 1 if non-negative, else restore and set bit to 0.
REQ-017 After the 4th step (edge N+4) outputs SHALL be written and the FSM SHALL enter DONE; done=1 in the following cycle only; next edge returns to IDLE.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); they are never both high.
REQ-019 start SHALL be ignored in RUN and DONE; latched operands SHALL not change if inputs change during RUN.
REQ-020 Quotient sign SHALL be dividend[4] XOR divisor[2], forced to 0 when quotient magnitude is 0 (no negative zero).
REQ-021 Remainder sign SHALL equal dividend[4] (truncating division), forced to 0 when remainder magnitude is 0; remainder magnitude SHALL always be < divisor magnitude.
REQ-022 Divide-by-zero SHALL skip RUN: enter DONE at edge N+1 with quotient=5'b0_0000, remainder=3'b0_00, zeroFlag=1, negativeFlag=0, divByZero=1.
REQ-023 divByZero SHALL be 0 for every non-zero divisor.
REQ-024 quotient, remainder, and all flags SHALL hold their values from DONE until the next accepted start updates them at completion.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE and clear quotient, remainder, busy, done, negativeFlag, and divByZero to 0, with zeroFlag=1.
REQ-026 Reset mid-RUN SHALL abort the operation with no done pulse.
REQ-027 rst SHALL take priority over start at the same edge.

Configuration
REQ-028 With DIV_REM_EN defined, the remainder port and its register SHALL exist per REQ-021.
REQ-029 Without DIV_REM_EN, the remainder port SHALL be absent; the partial remainder is internal only; all other behaviour and timing SHALL be unchanged.

Verification
REQ-030 The bench SHALL cover: 5'b0_1101 / 3'b0_11 -> done at N+5, quotient=5'b0_0100, remainder=3'b0_01, zeroFlag=0, negativeFlag=0.
REQ-031 The bench SHALL cover: 5'b1_1001 / 3'b0_10 -> quotient=5'b1_0100, remainder=3'b1_01, negativeFlag=1.
REQ-032 The bench SHALL cover: 5'b1_0001 / 3'b0_11 -> quotient=5'b0_0000, zeroFlag=1, negativeFlag=0, remainder=3'b1_01.
REQ-033 The bench SHALL cover: 5'b0_0111 / 3'b1_00 -> done at N+2, divByZero=1, quotient=0, zeroFlag=1, busy never high.
REQ-034 The bench SHALL cover: start re-asserted with new operands during RUN -> ignored, result matches original operands; rst at N+2 -> IDLE next cycle, no done pulse, outputs cleared.
